// File: rtl/uart_report_sched.sv
// -----------------------------------------------------------------------------
// uart_report_sched
//
// Schedules time reports from two requesters (a manual one-shot button request
// and a periodic auto-report timer on the 100 Hz tick) and serialises each
// report as a fixed ASCII frame onto a valid/ready UART TX byte interface.
//
// Frame: tag ('C' clock / 'S' stopwatch), HH ':' MM ':' SS '.' CC, then an
// optional CR LF. Each time field is clamped to 99 and sent as two digits.
//
// Ports:
//   iClk        system clock
//   iRstn       asynchronous active-low reset
//   iTick100Hz  one-cycle 100 Hz enable pulse (auto timer time base)
//   iReqBtn     one-cycle manual report request
//   iAutoEn     level, enables the periodic auto report
//   iMode       1 = clock mode (tag 'C'), 0 = stopwatch mode (tag 'S')
//   iHour/iMin/iSec/iCenti  current time fields (7 bits each)
//   iTxReady    transmitter can accept a byte this cycle
//   oTxValid    oTxData holds a valid byte (only while sending)
//   oTxData     ASCII byte of the frame
//   oBusy       frame being loaded or sent
//   oFrameDone  one-cycle pulse after the last byte has been accepted
// -----------------------------------------------------------------------------
module uart_report_sched #(
   parameter int unsigned P_AUTO_PERIOD = 32'd100,
   parameter bit          P_CRLF        = 1'b1
) (
   input  logic       iClk,
   input  logic       iRstn,
   input  logic       iTick100Hz,
   input  logic       iReqBtn,
   input  logic       iAutoEn,
   input  logic       iMode,
   input  logic [6:0] iHour,
   input  logic [6:0] iMin,
   input  logic [6:0] iSec,
   input  logic [6:0] iCenti,
   input  logic       iTxReady,
   output logic       oTxValid,
   output logic [7:0] oTxData,
   output logic       oBusy,
   output logic       oFrameDone
);

   localparam logic [3:0]  LAST_IDX  = P_CRLF ? 4'd13 : 4'd11;
   localparam logic [15:0] AUTO_LAST = 16'(P_AUTO_PERIOD - 32'd1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Clamp a field to 99 and return {tens, ones} as ASCII digits.
   function automatic logic [15:0] to_ascii2(input logic [6:0] v);
      logic [6:0] c;
      logic [6:0] tens;
      logic [6:0] ones;
      c    = (v > 7'd99) ? 7'd99 : v;
      tens = c / 7'd10;
      ones = c - (tens * 7'd10);
      return {8'h30 + {1'b0, tens}, 8'h30 + {1'b0, ones}};
   endfunction

   // Frame byte at position idx. dig holds {hour, min, sec, centi}, two
   // ASCII digits each, tens digit in the upper byte of every pair.
   function automatic logic [7:0] frame_byte(input logic [3:0]  idx,
                                             input logic        mode,
                                             input logic [63:0] dig);
      logic [7:0] b;
      case (idx)
         4'd0:    b = mode ? 8'h43 : 8'h53;
         4'd1:    b = dig[63:56];
         4'd2:    b = dig[55:48];
         4'd3:    b = 8'h3A;
         4'd4:    b = dig[47:40];
         4'd5:    b = dig[39:32];
         4'd6:    b = 8'h3A;
         4'd7:    b = dig[31:24];
         4'd8:    b = dig[23:16];
         4'd9:    b = 8'h2E;
         4'd10:   b = dig[15:8];
         4'd11:   b = dig[7:0];
         4'd12:   b = 8'h0D;
         4'd13:   b = 8'h0A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   state_t      state_q,     state_d;
   logic [3:0]  idx_q,       idx_d;
   logic [15:0] cnt_q,       cnt_d;
   logic        pend_btn_q,  pend_btn_d;
   logic        pend_auto_q, pend_auto_d;
   logic        mode_q,      mode_d;
   logic [63:0] dig_q,       dig_d;
   logic        tx_valid_q,  tx_valid_d;
   logic [7:0]  tx_data_q,   tx_data_d;
   logic        busy_q,      busy_d;
   logic        done_q,      done_d;
   logic        expire_s;

   // Next-state logic: auto timer, pending flags, arbitration, frame sequencing
   // and the next values of the registered outputs.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      cnt_d       = cnt_q;
      pend_btn_d  = pend_btn_q | iReqBtn;
      pend_auto_d = pend_auto_q;
      mode_d      = mode_q;
      dig_d       = dig_q;
      expire_s    = 1'b0;

      if (!iAutoEn) begin
         cnt_d = 16'd0;
      end else if (iTick100Hz) begin
         if (cnt_q == AUTO_LAST) begin
            cnt_d    = 16'd0;
            expire_s = 1'b1;
         end else begin
            cnt_d = cnt_q + 16'd1;
         end
      end else begin
         cnt_d = cnt_q;
      end

      case (state_q)
         ST_IDLE: begin
            // Manual wins; a button pulse this very cycle is served directly.
            if (pend_btn_q || iReqBtn) begin
               state_d    = ST_LOAD;
               pend_btn_d = 1'b0;
            end else if (pend_auto_q && iAutoEn) begin
               state_d     = ST_LOAD;
               pend_auto_d = 1'b0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOAD: begin
            mode_d  = iMode;
            dig_d   = {to_ascii2(iHour), to_ascii2(iMin),
                       to_ascii2(iSec),  to_ascii2(iCenti)};
            idx_d   = 4'd0;
            state_d = ST_SEND;
         end
         ST_SEND: begin
            // oTxValid is always high here, so iTxReady alone means acceptance.
            if (iTxReady) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end else begin
               state_d = ST_SEND;
            end
         end
         ST_DONE: begin
            idx_d   = 4'd0;
            state_d = ST_IDLE;
         end
         default: begin
            idx_d   = 4'd0;
            state_d = ST_IDLE;
         end
      endcase

      // A new expiry after serving still counts; disabling auto drops it.
      if (expire_s) begin
         pend_auto_d = 1'b1;
      end else begin
         pend_auto_d = pend_auto_d;
      end
      if (!iAutoEn) begin
         pend_auto_d = 1'b0;
      end else begin
         pend_auto_d = pend_auto_d;
      end

      // Outputs are registered from next-state values so they line up with
      // the state register without a cycle of lag.
      tx_valid_d = (state_d == ST_SEND);
      tx_data_d  = tx_valid_d ? frame_byte(idx_d, mode_d, dig_d) : 8'h00;
      busy_d     = (state_d == ST_LOAD) || (state_d == ST_SEND);
      done_d     = (state_d == ST_DONE);
   end

   // State, snapshot and output registers.
   always_ff @(posedge iClk or negedge iRstn) begin
      if (!iRstn) begin
         state_q     <= ST_IDLE;
         idx_q       <= 4'd0;
         cnt_q       <= 16'd0;
         pend_btn_q  <= 1'b0;
         pend_auto_q <= 1'b0;
         mode_q      <= 1'b0;
         dig_q       <= 64'd0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= 8'h00;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         cnt_q       <= cnt_d;
         pend_btn_q  <= pend_btn_d;
         pend_auto_q <= pend_auto_d;
         mode_q      <= mode_d;
         dig_q       <= dig_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign oTxValid   = tx_valid_q;
   assign oTxData    = tx_data_q;
   assign oBusy      = busy_q;
   assign oFrameDone = done_q;

endmodule

// File: tb/tb_uart_report_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_report_sched
//
// Directed bench. dut0 uses a 4-tick auto period with CR LF; dut1 uses a
// 4-tick auto period without CR LF (12-byte frames). Inputs are driven 1 ns
// after the rising edge and outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_uart_report_sched;

   logic       clk = 1'b0;
   logic       rstn;
   logic       tick;
   logic       req0;
   logic       req1;
   logic       auto0;
   logic       auto1;
   logic       mode;
   logic [6:0] hour;
   logic [6:0] minute;
   logic [6:0] sec;
   logic [6:0] centi;
   logic       ready;

   logic       v0, b0, fd0;
   logic [7:0] d0;
   logic       v1, b1, fd1;
   logic [7:0] d1;

   int         vecs = 0;
   int         errs = 0;
   logic [7:0] cap [0:31];
   int         ncap;
   logic [7:0] exp_c [0:13];
   logic [7:0] exp_s [0:11];

   always #5 clk = ~clk;

   uart_report_sched #(.P_AUTO_PERIOD(32'd4), .P_CRLF(1'b1)) dut0 (
      .iClk(clk), .iRstn(rstn), .iTick100Hz(tick), .iReqBtn(req0),
      .iAutoEn(auto0), .iMode(mode), .iHour(hour), .iMin(minute),
      .iSec(sec), .iCenti(centi), .iTxReady(ready),
      .oTxValid(v0), .oTxData(d0), .oBusy(b0), .oFrameDone(fd0));

   uart_report_sched #(.P_AUTO_PERIOD(32'd4), .P_CRLF(1'b0)) dut1 (
      .iClk(clk), .iRstn(rstn), .iTick100Hz(tick), .iReqBtn(req1),
      .iAutoEn(auto1), .iMode(mode), .iHour(hour), .iMin(minute),
      .iSec(sec), .iCenti(centi), .iTxReady(ready),
      .oTxValid(v1), .oTxData(d1), .oBusy(b1), .oFrameDone(fd1));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Record accepted bytes of the selected DUT until its frame-done pulse.
   task automatic capture(input bit which, input int budget, output bit timeout);
      ncap    = 0;
      timeout = 1'b1;
      for (int c = 0; c < budget; c++) begin
         if ((which ? v1 : v0) && ready) begin
            if (ncap < 32) cap[ncap] = which ? d1 : d0;
            ncap++;
         end
         if (which ? fd1 : fd0) begin
            timeout = 1'b0;
            break;
         end
         step();
      end
   endtask

   task automatic set_time_c();
      mode = 1'b1; hour = 7'd13; minute = 7'd45; sec = 7'd7; centi = 7'd32;
   endtask

   task automatic test_reset();
      rstn = 1'b1;
      #1 rstn = 1'b0;
      #10;
      vecs++;
      if ({v0, b0, fd0, d0} !== 11'd0)
         $display("FAIL reset_dut0: got v=%b b=%b fd=%b d=%h required all 0", v0, b0, fd0, d0);
      if ({v0, b0, fd0, d0} !== 11'd0) errs++;
      vecs++;
      if ({v1, b1, fd1, d1} !== 11'd0) begin
         $display("FAIL reset_dut1: got v=%b b=%b fd=%b d=%h required all 0", v1, b1, fd1, d1);
         errs++;
      end
      step(); step();
      rstn = 1'b1;
      step(); step();
      vecs++;
      if ({v0, b0, fd0} !== 3'b000) begin
         $display("FAIL idle_after_reset: got v=%b b=%b fd=%b required 000", v0, b0, fd0);
         errs++;
      end
   endtask

   task automatic test_manual();
      bit to;
      set_time_c();
      ready = 1'b1;
      req0 = 1'b1; step(); req0 = 1'b0;
      vecs++;
      if (b0 !== 1'b1 || v0 !== 1'b0) begin
         $display("FAIL load_cycle: got busy=%b valid=%b required busy=1 valid=0", b0, v0);
         errs++;
      end
      step();
      vecs++;
      if (v0 !== 1'b1 || d0 !== 8'h43) begin
         $display("FAIL first_byte_latency: got valid=%b data=%h required 1 43", v0, d0);
         errs++;
      end
      capture(1'b0, 40, to);
      vecs++;
      if (to || ncap != 14) begin
         $display("FAIL manual_len: got %0d bytes timeout=%b required 14", ncap, to);
         errs++;
      end
      for (int i = 0; i < 14; i++) begin
         vecs++;
         if (cap[i] !== exp_c[i]) begin
            $display("FAIL manual_byte%0d: got %h required %h", i, cap[i], exp_c[i]);
            errs++;
         end
      end
      vecs++;
      if (v0 !== 1'b0 || b0 !== 1'b0) begin
         $display("FAIL done_state: got valid=%b busy=%b required 0 0", v0, b0);
         errs++;
      end
      step();
      vecs++;
      if (fd0 !== 1'b0 || b0 !== 1'b0) begin
         $display("FAIL done_pulse_width: got fd=%b busy=%b required 0 0", fd0, b0);
         errs++;
      end
   endtask

   task automatic test_backpressure();
      bit to;
      bit ok;
      set_time_c();
      ready = 1'b1;
      req0 = 1'b1; step(); req0 = 1'b0;
      step();
      // Inputs change after LOAD; the snapshot must not follow them.
      hour = 7'd22; minute = 7'd0;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (v0 !== 1'b1 || d0 !== exp_c[i]) ok = 1'b0;
         step();
      end
      vecs++;
      if (!ok) begin
         $display("FAIL bp_head_bytes: got a wrong byte among 0..3 required C13:");
         errs++;
      end
      ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         step();
         vecs++;
         if (v0 !== 1'b1 || d0 !== 8'h34) begin
            $display("FAIL bp_hold%0d: got valid=%b data=%h required 1 34", k, v0, d0);
            errs++;
         end
      end
      ready = 1'b1;
      capture(1'b0, 40, to);
      vecs++;
      if (to || ncap != 10) begin
         $display("FAIL bp_tail_len: got %0d bytes timeout=%b required 10", ncap, to);
         errs++;
      end
      for (int i = 0; i < 10; i++) begin
         vecs++;
         if (cap[i] !== exp_c[4 + i]) begin
            $display("FAIL bp_byte%0d: got %h required %h", 4 + i, cap[i], exp_c[4 + i]);
            errs++;
         end
      end
      set_time_c();
      step();
   endtask

   task automatic test_arbitration();
      bit to;
      bit extra;
      set_time_c();
      ready = 1'b1;
      auto0 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick = 1'b1; step(); tick = 1'b0; step();
      end
      // Fourth tick expires the timer in the same cycle as the button.
      tick = 1'b1; req0 = 1'b1; step(); tick = 1'b0; req0 = 1'b0;
      capture(1'b0, 40, to);
      vecs++;
      if (to || ncap != 14) begin
         $display("FAIL arb_manual_len: got %0d bytes timeout=%b required 14", ncap, to);
         errs++;
      end
      step();
      vecs++;
      if (b0 !== 1'b0) begin
         $display("FAIL arb_idle_gap: got busy=%b required 0", b0);
         errs++;
      end
      step();
      vecs++;
      if (b0 !== 1'b1) begin
         $display("FAIL arb_auto_start: got busy=%b required 1", b0);
         errs++;
      end
      step();
      // Two button pulses during SEND coalesce into one pending request.
      req0 = 1'b1; step(); req0 = 1'b1; step(); req0 = 1'b0;
      capture(1'b0, 40, to);
      vecs++;
      if (to || ncap != 12 || cap[11] !== 8'h0A) begin
         $display("FAIL arb_auto_tail: got %0d bytes last=%h timeout=%b required 12 0a", ncap, cap[11], to);
         errs++;
      end
      step(); step();
      vecs++;
      if (b0 !== 1'b1) begin
         $display("FAIL arb_extra_start: got busy=%b required 1", b0);
         errs++;
      end
      capture(1'b0, 40, to);
      vecs++;
      if (to || ncap != 14) begin
         $display("FAIL arb_extra_len: got %0d bytes timeout=%b required 14", ncap, to);
         errs++;
      end
      extra = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (b0 || v0) extra = 1'b1;
      end
      vecs++;
      if (extra) begin
         $display("FAIL arb_no_more_frames: got activity=%b required 0", extra);
         errs++;
      end
      auto0 = 1'b0;
      step();
   endtask

   task automatic test_auto_period();
      bit   to;
      bit   prevb;
      bit   extra;
      int   starts;
      int   start_tick [0:3];
      for (int i = 0; i < 4; i++) start_tick[i] = 0;
      starts = 0;
      set_time_c();
      ready = 1'b1;
      auto0 = 1'b1;
      prevb = b0;
      for (int t = 1; t <= 8; t++) begin
         tick = 1'b1; step(); tick = 1'b0;
         for (int s = 0; s < 5; s++) begin
            if (b0 && !prevb) begin
               if (starts < 4) start_tick[starts] = t;
               starts++;
            end
            prevb = b0;
            if (s < 4) step();
         end
      end
      vecs++;
      if (starts != 2) begin
         $display("FAIL auto_frame_count: got %0d required 2", starts);
         errs++;
      end
      vecs++;
      if (start_tick[0] != 4 || start_tick[1] != 8) begin
         $display("FAIL auto_start_ticks: got %0d,%0d required 4,8", start_tick[0], start_tick[1]);
         errs++;
      end
      // Disable auto while the second frame is being sent.
      auto0 = 1'b0;
      capture(1'b0, 40, to);
      vecs++;
      if (to || ncap != 12 || cap[11] !== 8'h0A) begin
         $display("FAIL auto_disable_finish: got %0d bytes last=%h timeout=%b required 12 0a", ncap, cap[11], to);
         errs++;
      end
      extra = 1'b0;
      for (int t = 0; t < 8; t++) begin
         tick = 1'b1; step(); tick = 1'b0;
         for (int s = 0; s < 4; s++) begin
            if (b0 || v0) extra = 1'b1;
            step();
         end
      end
      vecs++;
      if (extra) begin
         $display("FAIL auto_disabled_quiet: got activity=%b required 0", extra);
         errs++;
      end
   endtask

   task automatic test_clamp();
      bit to;
      mode = 1'b0; hour = 7'd0; minute = 7'd5; sec = 7'd59; centi = 7'd120;
      ready = 1'b1;
      req1 = 1'b1; step(); req1 = 1'b0;
      capture(1'b1, 40, to);
      vecs++;
      if (to || ncap != 12) begin
         $display("FAIL clamp_len: got %0d bytes timeout=%b required 12", ncap, to);
         errs++;
      end
      for (int i = 0; i < 12; i++) begin
         vecs++;
         if (cap[i] !== exp_s[i]) begin
            $display("FAIL clamp_byte%0d: got %h required %h", i, cap[i], exp_s[i]);
            errs++;
         end
      end
      step();
   endtask

   task automatic test_reset_midframe();
      bit to;
      bit extra;
      set_time_c();
      ready = 1'b1;
      req0 = 1'b1; step(); req0 = 1'b0;
      step();
      for (int i = 0; i < 6; i++) step();
      vecs++;
      if (v0 !== 1'b1 || d0 !== 8'h3A) begin
         $display("FAIL midframe_setup: got valid=%b data=%h required 1 3a", v0, d0);
         errs++;
      end
      rstn = 1'b0;
      #1;
      vecs++;
      if ({v0, b0, fd0, d0} !== 11'd0) begin
         $display("FAIL async_reset: got v=%b b=%b fd=%b d=%h required all 0", v0, b0, fd0, d0);
         errs++;
      end
      step(); step();
      rstn = 1'b1;
      extra = 1'b0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (b0 || v0) extra = 1'b1;
      end
      vecs++;
      if (extra) begin
         $display("FAIL no_resume_after_reset: got activity=%b required 0", extra);
         errs++;
      end
      req0 = 1'b1; step(); req0 = 1'b0;
      capture(1'b0, 40, to);
      vecs++;
      if (to || ncap != 14 || cap[0] !== 8'h43 || cap[13] !== 8'h0A) begin
         $display("FAIL post_reset_frame: got %0d bytes first=%h last=%h required 14 43 0a", ncap, cap[0], cap[13]);
         errs++;
      end
   endtask

   initial begin
      exp_c = '{8'h43, 8'h31, 8'h33, 8'h3A, 8'h34, 8'h35, 8'h3A,
                8'h30, 8'h37, 8'h2E, 8'h33, 8'h32, 8'h0D, 8'h0A};
      exp_s = '{8'h53, 8'h30, 8'h30, 8'h3A, 8'h30, 8'h35, 8'h3A,
                8'h35, 8'h39, 8'h2E, 8'h39, 8'h39};
      tick = 1'b0; req0 = 1'b0; req1 = 1'b0; auto0 = 1'b0; auto1 = 1'b0;
      ready = 1'b0;
      set_time_c();
      test_reset();
      test_manual();
      test_backpressure();
      test_arbitration();
      test_auto_period();
      test_clamp();
      test_reset_midframe();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached before completion");
      $fatal(1, "watchdog");
   end

endmodule
